axi_burst_mem_slave: RTL and testbench

- AXI3-subset burst responder that models cached and uncached main memory for the data cache's bus master.
- Accepts 1–16-beat INCR read and write bursts: cache refills and write-backs use arlen/awlen = 15; uncached accesses use 0.
- Backed by an internal word-addressed array with byte-strobe writes.
- Sits on the memory side of the data-cache bus. Serves as the simulation memory model and as the on-chip scratch RAM behind the bus.

---
 rtl/axi_burst_mem_slave_pkg.sv | 7 +
 rtl/axi_burst_mem_slave_if.sv | 26 ++
 rtl/axi_burst_mem_slave_array.sv | 23 ++
 rtl/axi_burst_mem_slave.sv | 110 +++++++++++
 tb/tb_axi_burst_mem_slave.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_mem_slave_pkg.sv
// axi_burst_mem_slave_pkg: shared state encoding, response codes and burst-length width.
package axi_burst_mem_slave_pkg;
  localparam int LEN_W = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_RD_DELAY, S_RD_FETCH, S_RD_DATA, S_WR_DATA, S_WR_RESP} state_e;
endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// axi_burst_mem_slave_if: AXI3-subset read/write channels between the cache master and the memory slave.
interface axi_burst_mem_slave_if
  import axi_burst_mem_slave_pkg::*;
  ();
  logic [31:0] araddr;
  logic [LEN_W-1:0] arlen;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic rvalid, rlast, rready;
  logic [31:0] awaddr;
  logic [LEN_W-1:0] awlen;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic bvalid, bready;
  logic [1:0] bresp;
  modport master (
    output araddr, arlen, arvalid, rready, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arready, rdata, rvalid, rlast, awready, wready, bvalid, bresp
  );
  modport slave (
    input araddr, arlen, arvalid, rready, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rvalid, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_burst_mem_slave_array.sv
// axi_mem_array: single-port word RAM with synchronous read and per-byte write enables.
module axi_mem_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  // Read register holds its value when re_i is low so a stalled beat stays stable.
  always_ff @(posedge clk)
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave: one-outstanding-transaction INCR burst responder backed by a word RAM.
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int AW = 12,
  parameter int RD_WAIT = 0
) (
  input logic clk,
  input logic reset,
  axi_burst_mem_slave_if.slave bus
);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, ram_addr;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d, wait_q, wait_d;
  logic err_q, err_d, ram_re, last, unused_ok;
  logic [3:0] ram_we;
  assign last = beat_q == len_q;
  assign unused_ok = ^{bus.araddr[1:0], bus.araddr[31:AW+2], bus.awaddr[1:0], bus.awaddr[31:AW+2]};
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    beat_d = beat_q;
    wait_d = wait_q;
    err_d = err_q;
    ram_addr = addr_q;
    ram_re = 1'b0;
    ram_we = 4'h0;
    case (state_q)
      S_IDLE:
        if (bus.awvalid) begin
          state_d = S_WR_DATA;
          addr_d = bus.awaddr[AW+1:2];
          len_d = bus.awlen;
          beat_d = '0;
        end else if (bus.arvalid) begin
          state_d = RD_WAIT == 0 ? S_RD_FETCH : S_RD_DELAY;
          addr_d = bus.araddr[AW+1:2];
          len_d = bus.arlen;
          beat_d = '0;
          wait_d = '0;
        end
      S_RD_DELAY: begin
        wait_d = wait_q + 1'b1;
        state_d = wait_q == LEN_W'(RD_WAIT - 1) ? S_RD_FETCH : S_RD_DELAY;
      end
      S_RD_FETCH: begin
        ram_re = 1'b1;
        state_d = S_RD_DATA;
      end
      // Prefetch the next word on every accepted beat so consecutive beats have no bubble.
      S_RD_DATA:
        if (bus.rready) begin
          if (last) state_d = S_IDLE;
          else begin
            beat_d = beat_q + 1'b1;
            addr_d = addr_q + 1'b1;
            ram_addr = addr_q + 1'b1;
            ram_re = 1'b1;
          end
        end
      S_WR_DATA:
        if (bus.wvalid) begin
          ram_we = bus.wstrb;
          addr_d = addr_q + 1'b1;
          beat_d = beat_q + 1'b1;
          err_d = err_q | (bus.wlast != last);
          state_d = bus.wlast ? S_WR_RESP : S_WR_DATA;
        end
      S_WR_RESP:
        if (bus.bready) begin
          state_d = S_IDLE;
          err_d = 1'b0;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      wait_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      beat_q <= beat_d;
      wait_q <= wait_d;
      err_q <= err_d;
    end
  assign bus.awready = state_q == S_IDLE && !reset;
  assign bus.arready = state_q == S_IDLE && !reset && !bus.awvalid;
  assign bus.rvalid = state_q == S_RD_DATA;
  assign bus.rlast = state_q == S_RD_DATA && last;
  assign bus.wready = state_q == S_WR_DATA;
  assign bus.bvalid = state_q == S_WR_RESP;
  assign bus.bresp = state_q == S_WR_RESP && err_q ? RESP_SLVERR : RESP_OKAY;
  axi_mem_array #(.AW(AW)) u_mem (
    .clk(clk),
    .rst_i(reset),
    .addr_i(ram_addr),
    .re_i(ram_re),
    .we_i(ram_we),
    .wdata_i(bus.wdata),
    .rdata_o(bus.rdata)
  );
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb_axi_burst_mem_slave: directed and randomized bursts checked against a word-array memory model.
module tb_axi_burst_mem_slave;
  import axi_burst_mem_slave_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] model [4096];
  logic [31:0] wd[$];
  logic [3:0] ws[$];
  always #5 clk = ~clk;
  axi_burst_mem_slave_if bus ();
  axi_burst_mem_slave #(.AW(12), .RD_WAIT(0)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] widx(input logic [31:0] a, input int b);
    return a[13:2] + 12'(b);
  endfunction
  task automatic fill(input int n, input bit rnd_strb);
    wd.delete();
    ws.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back($urandom);
      ws.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask
  task automatic do_write(input logic [31:0] a, input int len, input int nb, input bit both);
    int hold;
    logic [11:0] w;
    @(negedge clk);
    bus.awaddr = a;
    bus.awlen = 4'(len);
    bus.awvalid = 1'b1;
    if (both) begin
      bus.araddr = a;
      bus.arlen = 4'(len);
      bus.arvalid = 1'b1;
    end
    #1;
    chk("awready", 32'(bus.awready), 1);
    chk("arready_blocked", 32'(bus.arready), 0);
    @(posedge clk);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
      end
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1;
      bus.wdata = wd[b];
      bus.wstrb = ws[b];
      bus.wlast = (b == nb - 1);
      #1;
      chk("wready", 32'(bus.wready), 1);
      @(posedge clk);
      w = widx(a, b);
      for (int i = 0; i < 4; i++)
        if (ws[b][i]) model[w][8*i +: 8] = wd[b][8*i +: 8];
    end
    hold = $urandom_range(0, 2);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      bus.wvalid = 1'b0;
      bus.wlast = 1'b0;
      bus.bready = (k == hold);
      #1;
      chk("bvalid", 32'(bus.bvalid), 1);
      chk("bresp", 32'(bus.bresp), 32'((nb - 1 == len) ? RESP_OKAY : RESP_SLVERR));
      @(posedge clk);
    end
    @(negedge clk);
    bus.bready = 1'b0;
    #1;
    chk("bvalid_drop", 32'(bus.bvalid), 0);
    if (both) chk("ar_after_b", 32'(bus.arready), 1);
  endtask
  // mode 0: rready=1, 1: pattern 1,0,0,1, 2: random. abort_at>=0 asserts reset at that beat.
  task automatic do_read(input logic [31:0] a, input int len, input int mode, input int abort_at, input bit pre);
    int lat, beat, cyc;
    logic rr;
    if (!pre) begin
      @(negedge clk);
      bus.araddr = a;
      bus.arlen = 4'(len);
      bus.arvalid = 1'b1;
      bus.rready = 1'b0;
      #1;
      chk("arready", 32'(bus.arready), 1);
    end
    @(posedge clk);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      bus.arvalid = 1'b0;
      lat++;
      #1;
      if (bus.rvalid) break;
    end
    chk("rd_latency", lat, 2);
    beat = 0;
    cyc = 0;
    while (beat <= len && cyc < 200 && lat < 20) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      rr = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      bus.rready = rr;
      chk("rvalid", 32'(bus.rvalid), 1);
      chk("rdata", bus.rdata, model[widx(a, beat)]);
      chk("rlast", 32'(bus.rlast), 32'(beat == len));
      if (beat == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        return;
      end
      @(posedge clk);
      if (rr) beat++;
      cyc++;
    end
    chk("rd_beats", beat, len + 1);
    @(negedge clk);
    bus.rready = 1'b0;
    #1;
    chk("rvalid_drop", 32'(bus.rvalid), 0);
  endtask
  initial begin
    bus.araddr = '0;
    bus.arlen = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awaddr = '0;
    bus.awlen = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wlast = 1'b0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 0);
    chk("rst_arready", 32'(bus.arready), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rlast", 32'(bus.rlast), 0);
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_bresp", 32'(bus.bresp), 0);
    chk("rst_rdata", bus.rdata, 0);
    reset = 1'b0;
    #1;
    chk("idle_awready", 32'(bus.awready), 1);
    chk("idle_arready", 32'(bus.arready), 1);
    wd.delete();
    ws.delete();
    for (int i = 0; i < 16; i++) begin
      wd.push_back(32'h100 + i);
      ws.push_back(4'hF);
    end
    do_write(32'h0000_1040, 15, 16, 1'b0);
    do_read(32'h0000_1040, 15, 0, -1, 1'b0);
    wd = '{32'h1122_3344};
    ws = '{4'hF};
    do_write(32'h0000_2000, 0, 1, 1'b0);
    wd = '{32'hAABB_CCDD};
    ws = '{4'h1};
    do_write(32'h0000_2000, 0, 1, 1'b0);
    do_read(32'h0000_2000, 0, 0, -1, 1'b0);
    fill(16, 1'b0);
    do_write(32'h0000_1040, 15, 16, 1'b1);
    do_read(32'h0000_1040, 15, 0, -1, 1'b1);
    do_read(32'h0000_1040, 15, 1, -1, 1'b0);
    fill(2, 1'b0);
    do_write(32'h0000_3000, 3, 2, 1'b0);
    fill(4, 1'b0);
    do_write(32'h0000_3000, 3, 4, 1'b0);
    fill(4, 1'b0);
    do_write(32'h0000_3100, 1, 4, 1'b0);
    do_read(32'h0000_3100, 3, 0, -1, 1'b0);
    fill(4, 1'b0);
    do_write(32'h0000_3FF8, 3, 4, 1'b0);
    do_read(32'h0000_0000, 1, 0, -1, 1'b0);
    do_read(32'h0000_3FF8, 3, 2, -1, 1'b0);
    do_read(32'hF000_3FF8, 3, 0, -1, 1'b0);
    do_read(32'h0000_1040, 15, 0, 7, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_mid_rvalid", 32'(bus.rvalid), 0);
    chk("rst_mid_rlast", 32'(bus.rlast), 0);
    reset = 1'b0;
    bus.rready = 1'b0;
    do_read(32'h0000_1040, 15, 2, -1, 1'b0);
    repeat (6) begin
      logic [31:0] a;
      int len;
      a = {18'h0, 12'($urandom), 2'($urandom)};
      len = $urandom_range(0, 15);
      fill(len + 1, 1'b0);
      do_write(a, len, len + 1, 1'b0);
      fill(len + 1, 1'b1);
      do_write(a, len, len + 1, 1'b0);
      do_read(a, len, 2, -1, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
